fifo_rd_arbiter: RTL and testbench

//   Shares the read port of the async FIFO (read-pointer/empty side) among NREQ

---
 rtl/fifo_rd_arb_pkg.sv | 25 ++
 rtl/fifo_rd_arbiter_rr_pick.sv | 48 ++++
 rtl/fifo_rd_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_arb_pkg
//   Shared definitions for the async-FIFO read-side arbiter: FSM state
//   encodings, counter widths and the owner-index width helper.
//   Used by: rr_pick, fifo_rd_arbiter.
//   Optional feature macro (used by the top): FIFO_RD_ARB_PRIO_EN.
// ---------------------------------------------------------------------------
package fifo_rd_arb_pkg;

  // Beat counter covers BURST_LEN up to 15; stall counter covers STALL_MAX up to 255.
  localparam int BEAT_W  = 4;
  localparam int STALL_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_BURST   = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;

  // Width of an owner index; at least one bit so a single requester still works.
  function automatic int owner_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches req_i starting at ptr_i+1 and
//   wrapping, and reports the first set requester.
//   Ports:
//     req_i   in   NREQ    request vector
//     ptr_i   in   IDX_W   index of the last owner (search starts just after)
//     pick_o  out  NREQ    one-hot winner, 0 when nothing requested
//     idx_o   out  IDX_W   winner index, 0 when nothing requested
//     any_o   out  1       at least one request present
// ---------------------------------------------------------------------------
module rr_pick
  import fifo_rd_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = owner_w(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  pick_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int               sum;
  logic [IDX_W-1:0] cand;

  // Walk NREQ candidates in priority order; the first hit latches via any_o.
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    sum    = 0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      sum  = (int'(ptr_i) + i) % NREQ;
      cand = sum[IDX_W-1:0];
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    if (any_o) begin
      pick_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rd_arbiter
//   Shares the read port of an async FIFO among NREQ consumers in the read
//   clock domain. One owner at a time gets a burst of up to BURST_LEN pops;
//   the grant is revoked after STALL_MAX cycles of waiting on an empty FIFO.
//   Popped words are returned as tagged, registered responses.
//   Ports:
//     rclk        in   1           read-domain clock (posedge)
//     rst_n       in   1           synchronous active-low reset
//     req         in   NREQ        per-requester read request (level)
//     gnt         out  NREQ        registered one-hot grant, 0 when idle
//     fifo_empty  in   1           FIFO empty flag
//     fifo_rdata  in   DATA_WIDTH  FIFO head word
//     fifo_rinc   out  1           combinational pop strobe
//     rsp_valid   out  1           one-cycle response strobe
//     rsp_id      out  IDX_W       owner index of the response
//     rsp_data    out  DATA_WIDTH  popped word
//   Configuration macro: FIFO_RD_ARB_PRIO_EN -- when defined, req[0] wins
//   every IDLE arbitration it takes part in (no preemption of a burst).
// ---------------------------------------------------------------------------
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_LEN  = 4,
  parameter  int STALL_MAX  = 8,
  localparam int IDX_W      = owner_w(NREQ)
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  output logic [NREQ-1:0]       gnt,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rinc,
  output logic                  rsp_valid,
  output logic [IDX_W-1:0]      rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BURST_LEN);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX);
  localparam logic [IDX_W-1:0]   PTR_RESET  = IDX_W'(NREQ - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  rsp_valid_q;
  logic [IDX_W-1:0]      rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic [NREQ-1:0]       rr_onehot;
  logic [IDX_W-1:0]      rr_idx;
  logic                  rr_any;
  logic [NREQ-1:0]       win_onehot;
  logic [IDX_W-1:0]      win_idx;
  logic                  owner_req;
  logic                  pop;
  logic                  stall_evt;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i  (req),
    .ptr_i  (rr_ptr_q),
    .pick_o (rr_onehot),
    .idx_o  (rr_idx),
    .any_o  (rr_any)
  );

`ifdef FIFO_RD_ARB_PRIO_EN
  // Requester 0 overrides the rotating pick; rr_ptr still follows the owner.
  assign win_onehot = req[0] ? NREQ'(1) : rr_onehot;
  assign win_idx    = req[0] ? '0       : rr_idx;
`else
  assign win_onehot = rr_onehot;
  assign win_idx    = rr_idx;
`endif

  assign owner_req = req[owner_q];
  // Gated by rst_n so nothing is popped on a reset edge mid-burst.
  assign pop       = rst_n & (state_q == ST_BURST) & owner_req & ~fifo_empty;
  assign stall_evt = (state_q == ST_BURST) & owner_req & fifo_empty;

  assign fifo_rinc = pop;
  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    beat_d   = beat_q;
    stall_d  = stall_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        // An empty FIFO blocks granting so an owner never starts by stalling.
        if (rr_any && !fifo_empty) begin
          state_d = ST_BURST;
          owner_d = win_idx;
          gnt_d   = win_onehot;
          beat_d  = '0;
          stall_d = '0;
        end
      end
      ST_BURST: begin
        // Both counters saturate at their exit threshold.
        if (pop) begin
          stall_d = '0;
          if (beat_q != BEAT_LAST) beat_d = beat_q + 1'b1;
        end else if (stall_evt && stall_q != STALL_LAST) begin
          stall_d = stall_q + 1'b1;
        end
        // Last-beat pop, request drop and stall timeout all merge into one exit.
        if (beat_d == BEAT_LAST || !owner_req || stall_d == STALL_LAST) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
        end
      end
      ST_RELEASE: begin
        state_d  = ST_IDLE;
        rr_ptr_d = owner_q;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      gnt_q       <= '0;
      beat_q      <= '0;
      stall_q     <= '0;
      rr_ptr_q    <= PTR_RESET;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      beat_q      <= beat_d;
      stall_q     <= stall_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= pop;
      // Response payload holds between pops.
      if (pop) begin
        rsp_id_q   <= owner_q;
        rsp_data_q <= fifo_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_arbiter
//   Directed bench for fifo_rd_arbiter (NREQ=4, DATA_WIDTH=8, BURST_LEN=4,
//   STALL_MAX=8). A queue models the FIFO contents. Inputs change on the
//   falling edge; the pop strobe is sampled just after, registered outputs
//   one time unit after the rising edge.
//   Expected grant in the final priority scenario depends on
//   FIFO_RD_ARB_PRIO_EN.
// ---------------------------------------------------------------------------
module tb_fifo_rd_arbiter;

  logic       rclk       = 1'b0;
  logic       rst_n      = 1'b0;
  logic [3:0] req        = 4'b0000;
  logic [3:0] gnt;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_rinc;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic [7:0] rsp_data;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] fifoQ[$];
  logic [7:0] pushWord = 8'h00;
  logic [7:0] expWord  = 8'h00;
  logic       rincSeen = 1'b0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rinc;
    logic [3:0] gnt;
    logic       rv;
    logic [1:0] rid;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[11];

  always #5 rclk = ~rclk;

  fifo_rd_arbiter #(
    .NREQ       (4),
    .DATA_WIDTH (8),
    .BURST_LEN  (4),
    .STALL_MAX  (8)
  ) dut (
    .rclk       (rclk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt        (gnt),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rinc  (fifo_rinc),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  task automatic syncFifo();
    fifo_empty = (fifoQ.size() == 0);
    fifo_rdata = fifo_empty ? 8'h00 : fifoQ[0];
  endtask

  task automatic loadWords(input int n);
    for (int i = 0; i < n; i++) begin
      fifoQ.push_back(pushWord);
      pushWord = pushWord + 8'h01;
    end
    syncFifo();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs, capture the pop strobe, advance the FIFO model.
  task automatic applyStimulus(input logic rstVal, input logic [3:0] reqVal);
    @(negedge rclk);
    rst_n = rstVal;
    req   = reqVal;
    #1;
    rincSeen = fifo_rinc;
    checkOutput("rinc_on_empty", {31'd0, rincSeen & fifo_empty}, 32'd0);
    @(posedge rclk);
    #1;
    if (rincSeen && fifoQ.size() > 0) void'(fifoQ.pop_front());
    syncFifo();
  endtask

  task automatic popCheck(input logic [3:0] reqVal, input logic [1:0] owner);
    applyStimulus(1'b1, reqVal);
    checkOutput("pop_rinc", {31'd0, rincSeen}, 32'd1);
    checkOutput("pop_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("pop_rsp_id", {30'd0, rsp_id}, {30'd0, owner});
    checkOutput("pop_rsp_data", {24'd0, rsp_data}, {24'd0, expWord});
    expWord = expWord + 8'h01;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0, 8'h00};
    vecs[1]  = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    vecs[2]  = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1};
    vecs[3]  = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA2};
    vecs[4]  = '{1'b1, 4'b0001, 1'b1, 4'b0000, 1'b1, 2'd0, 8'hA3};
    vecs[5]  = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA3};
    vecs[6]  = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0, 8'hA3};
    vecs[7]  = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA4};
    vecs[8]  = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA5};
    vecs[9]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA5};
    vecs[10] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA5};

    // Reset state
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("rst_gnt", {28'd0, gnt}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    checkOutput("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    checkOutput("rst_rinc", {31'd0, rincSeen}, 32'd0);

    // Single requester, six words: full burst, release, re-grant
    pushWord = 8'hA0;
    loadWords(6);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req);
      checkOutput("tbl_rinc", {31'd0, rincSeen}, {31'd0, vecs[i].rinc});
      checkOutput("tbl_gnt", {28'd0, gnt}, {28'd0, vecs[i].gnt});
      checkOutput("tbl_rsp_valid", {31'd0, rsp_valid}, {31'd0, vecs[i].rv});
      checkOutput("tbl_rsp_id", {30'd0, rsp_id}, {30'd0, vecs[i].rid});
      checkOutput("tbl_rsp_data", {24'd0, rsp_data}, {24'd0, vecs[i].rdata});
    end

    // All requesting, FIFO never empty: order 0,1,2,3,0
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0000);
    pushWord = 8'h10;
    expWord  = 8'h10;
    loadWords(20);
    for (int b = 0; b < 5; b++) begin
      applyStimulus(1'b1, 4'b1111);
      checkOutput("rr_gnt", {28'd0, gnt}, 32'd1 << (b % 4));
      for (int k = 0; k < 4; k++) popCheck(4'b1111, 2'(b % 4));
      checkOutput("rr_gnt_off", {28'd0, gnt}, 32'd0);
      applyStimulus(1'b1, 4'b1111);
      checkOutput("rr_release_rv", {31'd0, rsp_valid}, 32'd0);
    end

    // Owner 2 starves after one pop: grant revoked on the 8th stall cycle
    loadWords(1);
    applyStimulus(1'b1, 4'b0100);
    checkOutput("stall_gnt", {28'd0, gnt}, 32'h4);
    popCheck(4'b0100, 2'd2);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 4'b0100);
      checkOutput("stall_no_rinc", {31'd0, rincSeen}, 32'd0);
      checkOutput("stall_gnt_hold", {28'd0, gnt}, (k < 8) ? 32'h4 : 32'h0);
      checkOutput("stall_rv", {31'd0, rsp_valid}, 32'd0);
    end
    applyStimulus(1'b1, 4'b0000);
    checkOutput("stall_release_gnt", {28'd0, gnt}, 32'd0);

    // Owner 3 drops its request after two pops
    loadWords(8);
    applyStimulus(1'b1, 4'b1001);
    checkOutput("drop_gnt", {28'd0, gnt}, 32'h8);
    popCheck(4'b1001, 2'd3);
    popCheck(4'b1001, 2'd3);
    applyStimulus(1'b1, 4'b0001);
    checkOutput("drop_rinc", {31'd0, rincSeen}, 32'd0);
    checkOutput("drop_gnt_off", {28'd0, gnt}, 32'd0);
    applyStimulus(1'b1, 4'b0001);
    checkOutput("drop_release_gnt", {28'd0, gnt}, 32'd0);
    applyStimulus(1'b1, 4'b0001);
    checkOutput("drop_next_gnt", {28'd0, gnt}, 32'h1);

    // Reset in the middle of owner 0's burst
    popCheck(4'b0001, 2'd0);
    popCheck(4'b0001, 2'd0);
    applyStimulus(1'b0, 4'b0001);
    checkOutput("midrst_rinc", {31'd0, rincSeen}, 32'd0);
    checkOutput("midrst_gnt", {28'd0, gnt}, 32'd0);
    checkOutput("midrst_rv", {31'd0, rsp_valid}, 32'd0);
    checkOutput("midrst_fifo_level", fifoQ.size(), 32'd4);
    loadWords(12);
    applyStimulus(1'b1, 4'b1111);
    checkOutput("postrst_gnt", {28'd0, gnt}, 32'h1);
    for (int k = 0; k < 4; k++) popCheck(4'b1111, 2'd0);

    // Owner 1 bursting while req[0] and req[3] wait, rr_ptr at 0
    applyStimulus(1'b1, 4'b0010);
    applyStimulus(1'b1, 4'b0010);
    checkOutput("prio_owner1_gnt", {28'd0, gnt}, 32'h2);
    for (int k = 0; k < 4; k++) popCheck(4'b1011, 2'd1);
    applyStimulus(1'b1, 4'b1011);
    applyStimulus(1'b1, 4'b1011);
`ifdef FIFO_RD_ARB_PRIO_EN
    checkOutput("prio_next_gnt", {28'd0, gnt}, 32'h1);
`else
    checkOutput("prio_next_gnt", {28'd0, gnt}, 32'h8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
